// File: rtl/modbus_pkg.sv
// modbus_pkg: shared CRC constants, transmit state encoding and baud-derived timing helpers
package modbus_pkg;
    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, LEAD, ISSUE, WAIT, TAIL, GAP} tx_state_t;

    function automatic int char_cyc(input int clk_freq, input int baud_rate);
        return int'((longint'(clk_freq) * 10) / longint'(baud_rate));
    endfunction

    function automatic int t35_cyc(input int clk_freq, input int baud_rate);
        return int'((longint'(clk_freq) * 35) / longint'(baud_rate));
    endfunction
endpackage

// File: rtl/modbus_crc16.sv
// modbus_crc16: bit-serial Modbus CRC-16, one byte absorbed over 8 clocks
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        init,
    input  logic        load,
    input  logic [7:0]  din,
    output logic [15:0] crc,
    output logic        ready
);
    logic [7:0] sh;
    logic [3:0] cnt;
    logic       fb;

    assign fb    = crc[0] ^ sh[0];
    assign ready = cnt == 4'd0;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            crc <= CRC_INIT;
            sh  <= 8'h00;
            cnt <= 4'd0;
        end else if (init) begin
            crc <= CRC_INIT;
            cnt <= 4'd0;
        end else if (load) begin
            sh  <= din;
            cnt <= 4'd8;
        end else if (!ready) begin
            crc <= {1'b0, crc[15:1]} ^ (fb ? CRC_POLY : 16'h0000);
            sh  <= sh >> 1;
            cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: rtl/modbus_frame_tx_seq.sv
// modbus_frame_tx_seq: Modbus RTU response sequencer feeding a byte UART with CRC, RS-485 enable and 3.5-char gap
module modbus_frame_tx_seq
    import modbus_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int MAX_LEN   = 32,
    parameter int OE_LEAD   = 16,
    parameter int OE_TAIL   = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         buf_we,
    input  logic [$clog2(MAX_LEN)-1:0]   buf_addr,
    input  logic [7:0]                   buf_wdata,
    input  logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         tx_start,
    output logic [7:0]                   tx_data,
    input  logic                         tx_done,
    output logic                         rs485_oe
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN + 2);
    localparam logic [31:0] LEAD_CYC = 32'(OE_LEAD);
    localparam logic [31:0] TAIL_CYC = 32'(OE_TAIL);
    localparam logic [31:0] T35_CYC  = 32'(t35_cyc(CLK_FREQ, BAUD_RATE));
    localparam logic [31:0] TMO_CYC  = 32'(2 * char_cyc(CLK_FREQ, BAUD_RATE));

    tx_state_t     state;
    logic [7:0]    mem [MAX_LEN];
    logic [IW-1:0] idx, len, nidx;
    logic [31:0]   cnt;
    logic [7:0]    nbyte;
    logic [15:0]   crc;
    logic          len_ok, to_issue, crc_init, crc_load, crc_ready;

    assign len_ok   = frame_len != '0 && frame_len <= LW'(MAX_LEN);
    assign to_issue = (state == LEAD && cnt == LEAD_CYC - 32'd1) ||
                      (state == WAIT && tx_done && idx != len + IW'(1));
    // nidx/nbyte describe the byte about to be issued, so tx_data is registered with tx_start
    assign nidx     = state == LEAD ? '0 : idx + IW'(1);
    assign nbyte    = nidx < len ? mem[nidx[AW-1:0]] : nidx == len ? crc[7:0] : crc[15:8];
    assign crc_init = state == IDLE && start && len_ok;
    assign crc_load = to_issue && nidx < len && crc_ready;

    modbus_crc16 u_crc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .init     (crc_init),
        .load     (crc_load),
        .din      (nbyte),
        .crc      (crc),
        .ready    (crc_ready)
    );

    always_ff @(posedge clk_in) begin
        if (buf_we && state == IDLE) mem[buf_addr] <= buf_wdata;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            rs485_oe <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            len      <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            if (to_issue) begin
                state    <= ISSUE;
                idx      <= nidx;
                tx_data  <= nbyte;
                tx_start <= 1'b1;
                cnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && len_ok) begin
                            len      <= IW'(frame_len);
                            busy     <= 1'b1;
                            rs485_oe <= 1'b1;
                            cnt      <= '0;
                            state    <= LEAD;
                        end else if (start) begin
                            err <= 1'b1;
                        end
                    end
                    LEAD:  cnt <= cnt + 32'd1;
                    ISSUE: state <= WAIT;
                    WAIT: begin
                        if (tx_done) begin
                            cnt   <= '0;
                            state <= TAIL;
                        end else if (cnt == TMO_CYC - 32'd1) begin
                            err      <= 1'b1;
                            rs485_oe <= 1'b0;
                            cnt      <= '0;
                            state    <= GAP;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    TAIL: begin
                        if (cnt == TAIL_CYC - 32'd1) begin
                            rs485_oe <= 1'b0;
                            done     <= 1'b1;
                            cnt      <= '0;
                            state    <= GAP;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    GAP: begin
                        if (cnt == T35_CYC - 32'd1) begin
                            busy  <= 1'b0;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_modbus_frame_tx_seq.sv
// tb_modbus_frame_tx_seq: timeline model of a Modbus RTU transmit frame checked against the sequencer every cycle
module tb_modbus_frame_tx_seq;
    localparam int CF  = 1000000;
    localparam int BR  = 115200;
    localparam int ML  = 32;
    localparam int OL  = 5;
    localparam int OTL = 7;
    localparam int T35 = 35 * CF / BR;
    localparam int TMO = 2 * (10 * CF / BR);
    localparam int LAT = 20;
    localparam int INF = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       buf_we = 1'b0;
    logic [4:0] buf_addr = '0;
    logic [7:0] buf_wdata = '0;
    logic [5:0] frame_len = '0;
    logic       start = 1'b0;
    logic       tx_done;
    logic       busy, done, err, tx_start, rs485_oe;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    modbus_frame_tx_seq #(
        .CLK_FREQ(CF), .BAUD_RATE(BR), .MAX_LEN(ML), .OE_LEAD(OL), .OE_TAIL(OTL)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .frame_len(frame_len), .start(start), .busy(busy),
        .done(done), .err(err), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .rs485_oe(rs485_oe)
    );

    int checks = 0;
    int errors = 0;
    int t_on = INF, t_oe_off = INF, t_busy_off = INF, t_done = INF, t_err = INF;
    int next_issue = INF, zero_at = 0;
    int issued = 0, total = 0, withhold_n = 0, cd = 0;
    bit pend = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] m_buf [ML];
    logic [7:0] pl [$];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    function automatic int now();
        return int'($time / 10);
    endfunction

    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, m_buf[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 16'hA001 : c >> 1;
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            if (errors <= 40) $display("FAIL %s cycle %0d: got %0h want %0h", nm, now(), act, want);
        end
    endtask

    task automatic lit(input string nm, input int i, input logic [7:0] want);
        chk(nm, got_q.size() > i ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(want));
    endtask

    // every cycle: levels follow the frame timeline, pulses land exactly on their model cycle
    always @(negedge clk) begin
        int t;
        t = now();
        if (tx_start) begin
            got_q.push_back(tx_data);
            if (exp_q.size() > 0) cur_byte = exp_q.pop_front();
            zero_at = INF;
        end
        chk("busy", 32'(busy), 32'(t >= t_on && t < t_busy_off));
        chk("rs485_oe", 32'(rs485_oe), 32'(t >= t_on && t < t_oe_off));
        chk("done", 32'(done), 32'(t == t_done));
        chk("err", 32'(err), 32'(t == t_err));
        chk("tx_start", 32'(tx_start), 32'(t == next_issue));
        chk("tx_data", 32'(tx_data), 32'(t >= zero_at ? 8'h00 : cur_byte));
    end

    // UART stand-in: answers each tx_start with tx_done LAT clocks later unless that byte is withheld
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_start) begin
                issued++;
                pend = issued != withhold_n;
                cd = LAT;
                if (!pend) begin
                    t_err = now() + 1 + TMO;
                    t_oe_off = t_err;
                    t_busy_off = t_err + T35;
                end
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    tx_done = 1'b1;
                    pend = 0;
                    if (issued == total) begin
                        t_done = now() + 1 + OTL;
                        t_oe_off = t_done;
                        t_busy_off = t_done + T35;
                    end else begin
                        next_issue = now() + 1;
                    end
                end
            end
        end
    end

    task automatic load();
        foreach (pl[i]) begin
            @(negedge clk);
            buf_we = 1'b1;
            buf_addr = 5'(i);
            buf_wdata = pl[i];
            m_buf[i] = pl[i];
        end
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    task automatic kick(input int n);
        logic [15:0] c;
        @(negedge clk);
        start = 1'b1;
        frame_len = 6'(n);
        if (n >= 1 && n <= ML) begin
            exp_q.delete();
            got_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(m_buf[i]);
            c = crc16(n);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
            issued = 0;
            total = n + 2;
            t_on = now() + 1;
            next_issue = t_on + OL;
            t_oe_off = INF;
            t_busy_off = INF;
        end else begin
            t_err = now() + 1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk("idle_reached", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pl = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01};
        load(); kick(6); wait_idle();
        lit("f1_byte0", 0, 8'h01);
        lit("f1_crc_lo", 6, 8'hD5);
        lit("f1_crc_hi", 7, 8'hCA);

        pl = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        load(); kick(6); wait_idle();
        lit("f2_crc_lo", 6, 8'h98);
        lit("f2_crc_hi", 7, 8'h0B);

        pl = '{8'h01, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04};
        load(); kick(6); wait_idle();
        lit("f3_crc_lo", 6, 8'hA0);
        lit("f3_crc_hi", 7, 8'h09);

        kick(0); repeat (4) @(negedge clk);
        kick(ML + 1); repeat (4) @(negedge clk);

        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        load(); kick(5);
        for (int i = 0; i < 1000 && !done; i++) @(negedge clk);
        chk("gap_done_seen", 32'(done), 32'd1);
        repeat (10) @(negedge clk);
        buf_we = 1'b1; buf_addr = 5'd0; buf_wdata = 8'hEE; start = 1'b1; frame_len = 6'd3;
        @(negedge clk);
        buf_we = 1'b0; start = 1'b0;
        wait_idle();
        kick(5); wait_idle();
        lit("gap_buf_kept", 0, 8'h11);
        chk("gap_frame_len", 32'(got_q.size()), 32'd7);

        pl = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01};
        load();
        withhold_n = 3;
        kick(6); wait_idle();
        withhold_n = 0;
        chk("tmo_bytes_sent", 32'(got_q.size()), 32'd3);

        pl = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        load(); kick(6);
        for (int i = 0; i < 500 && issued < 2; i++) @(negedge clk);
        chk("rst_setup", 32'(issued), 32'd2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        pend = 0;
        t_busy_off = now() + 1;
        t_oe_off = now() + 1;
        zero_at = now() + 1;
        next_issue = INF;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        kick(6); wait_idle();
        lit("rst_crc_lo", 6, 8'h98);
        lit("rst_crc_hi", 7, 8'h0B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
